pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator, successor to the single-channel per-instance PWM generator array. It provides NUM_CH independent channels of WIDTH-bit resolution behind a single write port. Per-channel shadow registers give glitch-free period/duty updates at period boundaries. Each channel also has an output-polarity control and a period-end strobe for downstream sequencing, such as ADC triggers or phase-staggered drives.

Parameters:
NUM_CH, 4, number of PWM channels (1..32)
WIDTH, 8, bit width of period, pulse and counter (2..16)
CH_W, $clog2(NUM_CH) (min 1), width of channel index (derived, localparam)

Ports:
i_clock  in  1  system clock; all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_enable  in  NUM_CH  per-channel run enable, level-sensitive
i_wr_valid  in  1  write strobe for shadow registers, single-cycle accepted
i_wr_ch  in  CH_W  target channel of write; values >= NUM_CH ignored
i_wr_period  in  WIDTH  new period in clocks (0 = channel off)
i_wr_pulse  in  WIDTH  new high time in clocks
i_wr_invert  in  1  new output polarity (1 = active-low output)
o_pwm  out  NUM_CH  PWM outputs, registered
o_period_end  out  NUM_CH  one-cycle strobe, registered, marks last cycle of each period

Behaviour:
- Reset (i_reset high at a clock edge): all of the following clear to 0.
  - Shadow and active registers: period, pulse, invert.
  - Counters.
  - o_pwm and o_period_end.
- Reset wins over every other input in the same cycle. Reset mid-period aborts immediately, with no completion of the current period.
- Per channel state:
  - Shadow regs: sh_period, sh_pulse, sh_inv.
  - Active regs: act_period, act_pulse, act_inv.
  - Counter cnt[WIDTH-1:0].
- Write: when i_wr_valid=1 and i_wr_ch<NUM_CH, the shadow regs of that channel load at the clock edge. The write never touches active regs directly.
- Active-load (boundary) condition for channel k:
  - (i_enable[k]=0), or
  - (act_period=0), or
  - (cnt==act_period-1).
- When the boundary condition holds, active <= shadow, using the shadow value from before any same-cycle write.
  - A write landing in the boundary cycle is applied at the next boundary.
- Counter:
  - Disabled or act_period=0: cnt <= 0.
  - Otherwise cnt <= (cnt==act_period-1) ? 0 : cnt+1.
  - No wrap through 2^WIDTH: max period 2^WIDTH-1.
- Output, one cycle latency from cnt:
  - Enabled and act_period!=0: o_pwm[k] <= (cnt < act_pulse) ^ act_inv.
  - Disabled or act_period=0: o_pwm[k] <= act_inv (idle/inactive level).
- Duty edge cases:
  - act_pulse=0 gives permanently inactive output.
  - act_pulse >= act_period gives permanently active output. Unsigned compare; no special casing needed beyond that.
- o_period_end[k] <= enabled and act_period!=0 and cnt==act_period-1. With period=1 it is high every cycle.
- Channels are fully independent; no cross-channel phase relation except a common enable edge giving aligned starts.
- Enable fall: the counter returns to 0 next edge, and o_pwm goes to the idle level next edge. Re-enable always starts a fresh period at cnt=0 with the latest shadow values.

Test Plan:
- Reset then write ch0 period=10 pulse=3 inv=0, enable ch0 at cycle E -> o_pwm[0] high cycles E+2..E+4, low E+5..E+11, repeating every 10. o_period_end[0] is high at E+11, E+21, ...
- Four channels period=10 with pulses 1,2,3,4, common enable -> all rise together; widths are 1/2/3/4 clocks; o_period_end strobes coincide.
- Ch1 running period=10 pulse=2; write pulse=7 mid-period -> current period keeps a 2-clock high; next period shows 7. Repeat with the write in the cnt==9 cycle -> the change is deferred one full extra period.
- Edge duties: pulse=0 gives o_pwm constant 0; pulse=10 and pulse=255 with period=10 give constant 1; period=0 gives output = inv and no o_period_end; period=1 pulse=1 gives constant 1 with o_period_end every cycle.
- Polarity: inv=1, period=8 pulse=2 -> low 2 / high 6; disable -> o_pwm settles to 1 next edge. Write with i_wr_ch=NUM_CH -> no channel changes.
- Assert i_reset for 1 cycle mid-period on all channels -> next edge all outputs 0, shadows cleared. Re-enable without writes -> outputs stay 0.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: NUM_CH independent PWM channels sharing one shadow-register write port.
// Shadow values move to the active set only at a period boundary or while a channel is idle.
module pwm_multi_gen #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_enable,
    input  logic              i_wr_valid,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [WIDTH-1:0]  i_wr_period,
    input  logic [WIDTH-1:0]  i_wr_pulse,
    input  logic              i_wr_invert,
    output logic [NUM_CH-1:0] o_pwm,
    output logic [NUM_CH-1:0] o_period_end
);
    logic [WIDTH-1:0]  r_sh_period  [NUM_CH];
    logic [WIDTH-1:0]  r_sh_pulse   [NUM_CH];
    logic [WIDTH-1:0]  r_act_period [NUM_CH];
    logic [WIDTH-1:0]  r_act_pulse  [NUM_CH];
    logic [WIDTH-1:0]  r_cnt        [NUM_CH];
    logic [NUM_CH-1:0] r_sh_inv;
    logic [NUM_CH-1:0] r_act_inv;

    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_last;
    logic [NUM_CH-1:0] w_load;

    // Out-of-range channel indices never match any k, so such writes fall away.
    always_comb begin
        w_wr_hit = '0;
        w_run    = '0;
        w_last   = '0;
        w_load   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_wr_hit[k] = i_wr_valid && (i_wr_ch == CH_W'(k));
            w_run[k]    = i_enable[k] && (r_act_period[k] != '0);
            w_last[k]   = (r_act_period[k] != '0) &&
                          (r_cnt[k] == r_act_period[k] - WIDTH'(1));
            w_load[k]   = !w_run[k] || w_last[k];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_sh_period[k]  <= '0;
                r_sh_pulse[k]   <= '0;
                r_act_period[k] <= '0;
                r_act_pulse[k]  <= '0;
                r_cnt[k]        <= '0;
            end
            r_sh_inv     <= '0;
            r_act_inv    <= '0;
            o_pwm        <= '0;
            o_period_end <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_wr_hit[k]) begin
                    r_sh_period[k] <= i_wr_period;
                    r_sh_pulse[k]  <= i_wr_pulse;
                    r_sh_inv[k]    <= i_wr_invert;
                end
                // Non-blocking reads of the shadow regs defer a boundary-cycle write by one period.
                if (w_load[k]) begin
                    r_act_period[k] <= r_sh_period[k];
                    r_act_pulse[k]  <= r_sh_pulse[k];
                    r_act_inv[k]    <= r_sh_inv[k];
                end
                if (!w_run[k] || w_last[k]) begin
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + WIDTH'(1);
                end
                o_pwm[k]        <= w_run[k] ? ((r_cnt[k] < r_act_pulse[k]) ^ r_act_inv[k])
                                            : r_act_inv[k];
                o_period_end[k] <= w_run[k] && w_last[k];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: stimulus queues per-cycle expectations, a monitor pops them.
// dut_b (3 channels) exercises the out-of-range channel write.
module tb_pwm_multi_gen;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] en;
    logic       wr_valid;
    logic [1:0] wr_ch;
    logic [7:0] wr_period;
    logic [7:0] wr_pulse;
    logic       wr_inv;
    logic [3:0] pwm;
    logic [3:0] pend;

    logic [2:0] b_en;
    logic       b_wr_valid;
    logic [1:0] b_wr_ch;
    logic [2:0] b_pwm;
    logic [2:0] b_pend;

    pwm_multi_gen #(.NUM_CH(4), .WIDTH(8)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .i_wr_valid(wr_valid), .i_wr_ch(wr_ch), .i_wr_period(wr_period),
        .i_wr_pulse(wr_pulse), .i_wr_invert(wr_inv),
        .o_pwm(pwm), .o_period_end(pend)
    );

    pwm_multi_gen #(.NUM_CH(3), .WIDTH(8)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_enable(b_en),
        .i_wr_valid(b_wr_valid), .i_wr_ch(b_wr_ch), .i_wr_period(wr_period),
        .i_wr_pulse(wr_pulse), .i_wr_invert(wr_inv),
        .o_pwm(b_pwm), .o_period_end(b_pend)
    );

    typedef struct {
        logic [3:0] pwm;
        logic [3:0] pend;
        logic [3:0] mask;
        logic [2:0] b_pwm;
        logic [2:0] b_pend;
        logic [2:0] b_mask;
        int         idx;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] p, input logic [3:0] e, input logic [3:0] m,
                        input logic [2:0] bp, input logic [2:0] be, input logic [2:0] bm,
                        input int idx, input string nm);
        exp_t x;
        x.pwm = p; x.pend = e; x.mask = m;
        x.b_pwm = bp; x.b_pend = be; x.b_mask = bm;
        x.idx = idx;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: compares the outputs that follow each active edge against the queued expectation.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ((((pwm ^ x.pwm) & x.mask) !== 4'b0) ||
                    (((pend ^ x.pend) & x.mask) !== 4'b0) ||
                    (((b_pwm ^ x.b_pwm) & x.b_mask) !== 3'b0) ||
                    (((b_pend ^ x.b_pend) & x.b_mask) !== 3'b0)) begin
                    errors++;
                    $display("FAIL %s step %0d: got pwm=%b end=%b b_pwm=%b b_end=%b, want pwm=%b end=%b b_pwm=%b b_end=%b (mask %b/%b)",
                             nm, x.idx, pwm, pend, b_pwm, b_pend,
                             x.pwm, x.pend, x.b_pwm, x.b_pend, x.mask, x.b_mask);
                end
            end
        end
    end

    task automatic write_a(input int ch, input int p, input int d, input logic i);
        wr_valid  = 1'b1;
        wr_ch     = 2'(ch);
        wr_period = 8'(p);
        wr_pulse  = 8'(d);
        wr_inv    = i;
        tick();
        wr_valid  = 1'b0;
    endtask

    task automatic write_b(input int ch, input int p, input int d, input logic i);
        b_wr_valid = 1'b1;
        b_wr_ch    = 2'(ch);
        wr_period  = 8'(p);
        wr_pulse   = 8'(d);
        wr_inv     = i;
        tick();
        b_wr_valid = 1'b0;
    endtask

    // One channel alone: write, wait for idle level, run n cycles, disable and check idle level.
    task automatic run_case(input int ch, input int p, input int d, input logic i,
                            input int ncyc, input string nm);
        logic [3:0] pv, ev, mv;
        mv = '0; mv[ch] = 1'b1;
        write_a(ch, p, d, i);
        tick();
        pv = '0; pv[ch] = i;
        push(pv, 4'b0, mv, 3'b0, 3'b0, 3'b0, 0, {nm, "_idle"});
        tick();
        en[ch] = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            pv = '0; ev = '0;
            if (p == 0) begin
                pv[ch] = i;
            end else begin
                pv[ch] = (((n - 1) % p) < d) ^ i;
                ev[ch] = (((n - 1) % p) == p - 1);
            end
            push(pv, ev, mv, 3'b0, 3'b0, 3'b0, n, nm);
            tick();
        end
        en[ch] = 1'b0;
        pv = '0; pv[ch] = i;
        push(pv, 4'b0, mv, 3'b0, 3'b0, 3'b0, ncyc + 1, {nm, "_off"});
        tick();
    endtask

    // Ch1 runs period 10 pulse 2; at edge w the pulse is rewritten to 7.
    task automatic mid_write(input int w, input string nm);
        int beff;
        int pl;
        logic [3:0] pv, ev;
        beff = (w / 10 + 1) * 10;
        write_a(1, 10, 2, 1'b0);
        tick();
        tick();
        en[1] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            if (n == w) begin
                wr_valid = 1'b1; wr_ch = 2'd1; wr_period = 8'd10; wr_pulse = 8'd7; wr_inv = 1'b0;
            end else begin
                wr_valid = 1'b0;
            end
            pl = (n <= beff) ? 2 : 7;
            pv = '0; ev = '0;
            pv[1] = (((n - 1) % 10) < pl);
            ev[1] = (((n - 1) % 10) == 9);
            push(pv, ev, 4'b0010, 3'b0, 3'b0, 3'b0, n, nm);
            tick();
        end
        wr_valid = 1'b0;
        en[1] = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [3:0] pv, ev;
        logic [2:0] bpv, bev;
        rst = 1'b1; en = '0; wr_valid = 1'b0; wr_ch = '0;
        wr_period = '0; wr_pulse = '0; wr_inv = 1'b0;
        b_en = '0; b_wr_valid = 1'b0; b_wr_ch = '0;
        tick();
        push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b111, 0, "reset");
        tick();
        rst = 1'b0;
        push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b111, 1, "post_reset");
        tick();

        run_case(0, 10, 3, 1'b0, 25, "ch0_p10_d3");

        for (int k = 0; k < 4; k++) write_a(k, 10, k + 1, 1'b0);
        tick();
        push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b0, 0, "four_idle");
        tick();
        en = 4'hF;
        for (int n = 1; n <= 20; n++) begin
            for (int k = 0; k < 4; k++) pv[k] = (((n - 1) % 10) < k + 1);
            ev = (((n - 1) % 10) == 9) ? 4'hF : 4'h0;
            push(pv, ev, 4'hF, 3'b0, 3'b0, 3'b0, n, "four_ch");
            tick();
        end
        en = '0;
        push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b0, 21, "four_off");
        tick();

        mid_write(4, "mid_write");
        mid_write(10, "boundary_write");

        run_case(2, 10, 0,   1'b0, 12, "pulse0");
        run_case(2, 10, 10,  1'b0, 12, "pulse_eq_period");
        run_case(2, 10, 255, 1'b0, 12, "pulse255");
        run_case(2, 0,  5,   1'b0, 6,  "period0_inv0");
        run_case(2, 0,  5,   1'b1, 6,  "period0_inv1");
        run_case(2, 1,  1,   1'b0, 6,  "period1");
        run_case(3, 8,  2,   1'b1, 20, "invert_p8_d2");

        write_b(0, 4, 1, 1'b0);
        tick();
        tick();
        b_en = 3'b111;
        for (int n = 1; n <= 16; n++) begin
            if (n == 5) begin
                b_wr_valid = 1'b1; b_wr_ch = 2'd3; wr_period = 8'd2; wr_pulse = 8'd2; wr_inv = 1'b1;
            end else begin
                b_wr_valid = 1'b0;
            end
            bpv = '0; bev = '0;
            bpv[0] = (((n - 1) % 4) < 1);
            bev[0] = (((n - 1) % 4) == 3);
            push(4'b0, 4'b0, 4'b0, bpv, bev, 3'b111, n, "bad_channel_write");
            tick();
        end
        b_wr_valid = 1'b0;
        b_en = '0;
        tick();

        for (int k = 0; k < 4; k++) write_a(k, 6, 3, k[0]);
        tick();
        tick();
        en = 4'hF;
        for (int n = 1; n <= 5; n++) begin
            for (int k = 0; k < 4; k++) pv[k] = (((n - 1) % 6) < 3) ^ k[0];
            ev = (((n - 1) % 6) == 5) ? 4'hF : 4'h0;
            push(pv, ev, 4'hF, 3'b0, 3'b0, 3'b0, n, "pre_reset_run");
            tick();
        end
        rst = 1'b1;
        wr_valid = 1'b1; wr_ch = 2'd0; wr_period = 8'd3; wr_pulse = 8'd3; wr_inv = 1'b1;
        push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b111, 0, "mid_reset");
        tick();
        rst = 1'b0;
        wr_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            push(4'b0, 4'b0, 4'hF, 3'b0, 3'b0, 3'b111, n, "after_reset_enabled");
            tick();
        end
        en = '0;

        for (int t = 0; t < 5 && exp_q.size() > 0; t++) tick();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
